lfsr16_gen: RTL
===============

# lfsr16_gen

- 16-bit Galois LFSR pseudo-random word generator.
- Sits directly downstream of the seed holding register: it takes the registered 16-bit seed, loads it on command, and streams a programmed number of pseudo-random words to the consumer.
- Uses a valid/ready handshake on the output side.
- Guards against the all-zero lock-up state and reports completion with a one-cycle pulse.

## Interface
Parameters:
- WIDTH, 16, LFSR and data width (only 16 is supported).
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1, maximal length).
- RESET_SEED, 16'hACE1, LFSR contents after reset; must be nonzero.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- seed  in  16  seed word from the seed register.
- seed_ld  in  1  load seed into LFSR; honoured in IDLE only.
- start  in  1  begin a burst; honoured in IDLE only.
- count  in  8  number of words in the burst; sampled on an accepted start.
- out_ready  in  1  consumer can accept a word.
- rnd  out  16  current LFSR contents (output word).
- rnd_valid  out  1  rnd holds a valid word.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at end of burst.
- seed_err  out  1  last seed_ld carried zero; sticky until a nonzero seed_ld.

## Operation
- Step function (right-shift Galois): next = (s >> 1) ^ (s[0] ? TAPS : 0).
- rnd is the state register itself.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - seed_ld with seed != 0: state <= seed, seed_err <= 0.
  - seed_ld with seed == 0: state unchanged, seed_err <= 1.
  - start with count == 0: go to DONE, no words produced.
  - start with count != 0: state <= step(base), remaining <= count, go to RUN. base is the incoming seed when seed_ld and a nonzero seed arrive in the same cycle; otherwise base is the current state.
  - start in the same cycle as seed_ld with a zero seed: rejected, FSM stays in IDLE.
- RUN:
  - rnd_valid = 1. rnd is held stable while out_ready = 0.
  - On a transfer (rnd_valid & out_ready): remaining decrements.
  - If remaining was 1: go to DONE, state not stepped.
  - Otherwise: state <= step(state).
- DONE: done = 1 for exactly one cycle, then IDLE.
- seed_ld and start are ignored in RUN and DONE; seed_err is unchanged by them.
- The state register can never become zero: reset and loads are nonzero, and the step of a nonzero value is nonzero.
- Reset mid-burst: immediate return to IDLE; all outputs take their reset values and the burst is abandoned.

## Timing
- Reset values: rnd = RESET_SEED (0xACE1), rnd_valid = 0, busy = 0, done = 0, seed_err = 0, FSM = IDLE.
- Start accepted at edge k: rnd_valid = 1 and busy = 1 from after edge k. First word is available one cycle after start.
- Back-to-back throughput: one word per cycle while out_ready = 1.
- Last transfer at edge m: rnd_valid = 0 and done = 1 after edge m. IDLE (busy = 0) after edge m+1. A new start is accepted from edge m+2.
- count = 0: done pulses in the cycle after start; rnd_valid never rises.
- seed_ld takes effect at the same edge; seed_err updates at that edge.
- rnd after a burst holds the last transferred word until the next load or start.

## Structure
- Package lfsr_pkg holds:
  - the TAPS and RESET_SEED defaults;
  - the state enum {IDLE, RUN, DONE};
  - the function lfsr_step(logic [15:0]).
- One natural sub-module, lfsr16_core:
  - state register with load and step enables;
  - asynchronous reset to RESET_SEED.
- lfsr16_gen contains the FSM, the remaining counter and the handshake logic, and instantiates lfsr16_core.

## Test plan
- Reset, then seed_ld with 0x0001, then start with count = 3 and out_ready held 1 -> rnd sequence 0xB400, 0x5A00, 0x2D00 on consecutive cycles; done pulse after the third transfer.
- No seed_ld after reset, start with count = 1 -> rnd = 0xE270 with rnd_valid = 1, then done.
- Seed 0x0001, count = 2, out_ready low for 4 cycles -> rnd held at 0xB400 with valid high; after ready rises, 0x5A00 follows, then done.
- seed_ld with 0x0000 -> seed_err = 1 and rnd unchanged. A later start in the same cycle as seed_ld 0x0000 is rejected. seed_ld with 0x1234 -> seed_err = 0.
- Edge cases:
  - start with count = 0 -> done one cycle later, no valid.
  - seed_ld/start asserted during RUN -> ignored; sequence and count unaffected.
- rst_n asserted mid-burst (after 1 of 5 words) -> rnd = 0xACE1, valid, busy and done all 0 immediately. A new burst from 0xACE1 yields 0xE270 first.

Source files
------------

// File: rtl/lfsr_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | lfsr_pkg                                                                |
// | Shared defaults, FSM encoding and step function for the LFSR generator. |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package lfsr_pkg;

  localparam logic [15:0] C_TAPS       = 16'hB400;
  localparam logic [15:0] C_RESET_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gen_state_t;

  // Right-shift Galois step; a nonzero input always yields a nonzero result.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s,
                                            input logic [15:0] taps = C_TAPS);
    return (s >> 1) ^ (s[0] ? taps : 16'h0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16_core.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | lfsr16_core                                                             |
// | LFSR state register with parallel load and single-step enables.         |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module lfsr16_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAPS       = C_TAPS,
  parameter logic [WIDTH-1:0] RESET_SEED = C_RESET_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_en,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             step_en,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] r_lfsr;

  // Load has priority; the controller never asserts both in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= RESET_SEED;
    end else if (ld_en) begin
      r_lfsr <= ld_val;
    end else if (step_en) begin
      r_lfsr <= lfsr_step(r_lfsr, TAPS);
    end
  end

  assign state = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/lfsr16_gen.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | lfsr16_gen                                                              |
// | Seeded burst generator of pseudo-random words with valid/ready output.  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module lfsr16_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAPS       = C_TAPS,
  parameter logic [WIDTH-1:0] RESET_SEED = C_RESET_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] seed,
  input  logic             seed_ld,
  input  logic             start,
  input  logic [7:0]       count,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rnd,
  output logic             rnd_valid,
  output logic             busy,
  output logic             done,
  output logic             seed_err
);

  gen_state_t       r_state;
  gen_state_t       w_state_nxt;
  logic [7:0]       r_remaining;
  logic [7:0]       w_remaining_nxt;
  logic             r_seed_err;
  logic             w_seed_err_nxt;

  logic             w_ld_en;
  logic [WIDTH-1:0] w_ld_val;
  logic             w_step_en;
  logic             w_seed_ok;
  logic             w_seed_zero;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_lfsr;

  assign w_seed_ok   = seed_ld && (seed != '0);
  assign w_seed_zero = seed_ld && (seed == '0);
  // A same-cycle nonzero seed becomes the starting point of the burst.
  assign w_base      = w_seed_ok ? seed : w_lfsr;

  lfsr16_core #(
    .WIDTH      (WIDTH),
    .TAPS       (TAPS),
    .RESET_SEED (RESET_SEED)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_en   (w_ld_en),
    .ld_val  (w_ld_val),
    .step_en (w_step_en),
    .state   (w_lfsr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining <= 8'd0;
      r_seed_err  <= 1'b0;
    end else begin
      r_remaining <= w_remaining_nxt;
      r_seed_err  <= w_seed_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_seed_err_nxt  = r_seed_err;
    w_ld_en         = 1'b0;
    w_ld_val        = seed;
    w_step_en       = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_seed_ok) begin
          w_ld_en        = 1'b1;
          w_ld_val       = seed;
          w_seed_err_nxt = 1'b0;
        end else if (w_seed_zero) begin
          w_seed_err_nxt = 1'b1;
        end

        // A start paired with a rejected zero seed is dropped as well.
        if (start && !w_seed_zero) begin
          if (count == 8'd0) begin
            w_state_nxt = DONE;
          end else begin
            w_ld_en         = 1'b1;
            w_ld_val        = lfsr_step(w_base, TAPS);
            w_remaining_nxt = count;
            w_state_nxt     = RUN;
          end
        end
      end

      RUN: begin
        if (out_ready) begin
          w_remaining_nxt = r_remaining - 8'd1;
          if (r_remaining == 8'd1) begin
            w_state_nxt = DONE;
          end else begin
            w_step_en = 1'b1;
          end
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign rnd       = w_lfsr;
  assign rnd_valid = (r_state == RUN);
  assign busy      = (r_state == RUN) || (r_state == DONE);
  assign done      = (r_state == DONE);
  assign seed_err  = r_seed_err;

endmodule
`default_nettype wire
